// File: rtl/m_dmem_lsu.sv
// m_dmem_lsu -- data memory with an RV32I load/store unit.
//
// Handles byte, halfword and word loads and stores, with sign or zero
// extension on loads. Requests that are misaligned, out of range or carry an
// illegal funct3 are reported as faults. A valid/ready request and response
// handshake sits in front of a configurable access latency. At most one
// request is in flight at a time.
//
// Parameters
//   DEPTH    number of 32-bit words (power of 2, >= 2)
//   LATENCY  cycles from request acceptance to w_rsp_valid (>= 1)
//
// Ports
//   w_clk        in   1   clock; all state changes on posedge
//   w_rst        in   1   synchronous active-high reset
//   w_req_valid  in   1   request present
//   w_req_ready  out  1   block can accept a request (IDLE)
//   w_req_we     in   1   1 = store, 0 = load
//   w_req_funct3 in   3   000 b, 001 h, 010 w, 100 bu, 101 hu
//   w_req_addr   in   32  byte address
//   w_req_wdata  in   32  store data; low bits used for b/h
//   w_rsp_valid  out  1   response present (RESP)
//   w_rsp_ready  in   1   consumer accepts response
//   w_rsp_rdata  out  32  extended load result; 0 for stores and faults
//   w_rsp_fault  out  1   request faulted
module m_dmem_lsu #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 1
) (
    input  logic        w_clk,
    input  logic        w_rst,
    input  logic        w_req_valid,
    output logic        w_req_ready,
    input  logic        w_req_we,
    input  logic [2:0]  w_req_funct3,
    input  logic [31:0] w_req_addr,
    input  logic [31:0] w_req_wdata,
    output logic        w_rsp_valid,
    input  logic        w_rsp_ready,
    output logic [31:0] w_rsp_rdata,
    output logic        w_rsp_fault
);

    localparam int IDXW = $clog2(DEPTH);
    localparam int CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_accept;
    logic [31:0]     r_mem [DEPTH];
    logic [31:0]     r_rdata;
    logic            r_fault;

    logic [IDXW-1:0] w_idx;
    logic [1:0]      w_lane;
    logic [31:0]     w_rd_word;
    logic            w_legal;
    logic            w_misalign;
    logic            w_oob;
    logic            w_fault;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata_lane;
    logic            w_wr_en;

    // Select the addressed lane(s) of a word and extend them per funct3.
    function automatic logic [31:0] f_load_ext(input logic [31:0] word,
                                               input logic [2:0]  funct3,
                                               input logic [1:0]  lane);
        logic [7:0]  v_b;
        logic [15:0] v_h;
        logic [31:0] v_res;
        v_b = word[{lane, 3'b000} +: 8];
        v_h = lane[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  v_res = {{24{v_b[7]}}, v_b};
            3'b001:  v_res = {{16{v_h[15]}}, v_h};
            3'b010:  v_res = word;
            3'b100:  v_res = {24'd0, v_b};
            3'b101:  v_res = {16'd0, v_h};
            default: v_res = 32'd0;
        endcase
        return v_res;
    endfunction

    assign w_idx     = w_req_addr[IDXW+1:2];
    assign w_lane    = w_req_addr[1:0];
    assign w_rd_word = r_mem[w_idx];

    // Request decode: legality, alignment, range, byte enables and lane data.
    always_comb begin
        w_legal      = 1'b0;
        w_misalign   = 1'b0;
        w_be         = 4'b0000;
        w_wdata_lane = 32'd0;
        case (w_req_funct3)
            3'b000: begin
                w_legal      = 1'b1;
                w_be         = 4'b0001 << w_lane;
                w_wdata_lane = {4{w_req_wdata[7:0]}};
            end
            3'b001: begin
                w_legal      = 1'b1;
                w_misalign   = w_lane[0];
                w_be         = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata_lane = {2{w_req_wdata[15:0]}};
            end
            3'b010: begin
                w_legal      = 1'b1;
                w_misalign   = (w_lane != 2'b00);
                w_be         = 4'b1111;
                w_wdata_lane = w_req_wdata;
            end
            // Unsigned variants exist only for loads.
            3'b100: begin
                w_legal = ~w_req_we;
            end
            3'b101: begin
                w_legal    = ~w_req_we;
                w_misalign = w_lane[0];
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
        // Any address bit above the word index means the address is past the array.
        w_oob   = ((w_req_addr >> (IDXW + 2)) != 32'd0);
        w_fault = ~w_legal | w_misalign | w_oob;
    end

    // Next-state, counter and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (w_req_valid) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = CNT_INIT;
                    w_state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - CW'(1);
                // Counter reaches zero on this edge: response goes out next cycle.
                if (r_cnt <= CW'(1)) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_RESP: begin
                w_rsp_valid = 1'b1;
                if (w_rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = {CW{1'b0}};
            end
        endcase
    end

    // Reset wins over an acceptance in the same cycle, so a store is suppressed too.
    assign w_wr_en = w_accept & ~w_rst & w_req_we & ~w_fault;

    // State, counter and captured response registers.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= {CW{1'b0}};
            r_rdata <= 32'd0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_rdata <= (w_fault | w_req_we) ? 32'd0
                         : f_load_ext(w_rd_word, w_req_funct3, w_lane);
                r_fault <= w_fault;
            end else begin
                r_rdata <= r_rdata;
                r_fault <= r_fault;
            end
        end
    end

    // Byte-lane writes into the array; the array is not cleared by reset.
    always_ff @(posedge w_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_wr_en && w_be[b]) begin
                r_mem[w_idx][8*b +: 8] <= w_wdata_lane[8*b +: 8];
            end
        end
    end

    assign w_rsp_rdata = r_rdata;
    assign w_rsp_fault = r_fault;

endmodule
